// File: rtl/tile_compress_ctrl.sv
// Tile compression sequencer: buffers a 32-pixel RGBA tile, builds the min header,
// then streams header + 32 payload beats (deltas or raw). Optional counters: TILE_STATS_EN.
module tile_compress_ctrl #(
    parameter int DELTA_BITS  = 4,
    parameter int TILE_PIXELS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_data,
    output logic        out_is_hdr,
    output logic        out_last,
    output logic        out_compressed,
    output logic [31:0] stat_tiles_comp,
    output logic [31:0] stat_tiles_raw
);
    // Handshake: a beat/pixel transfers on a rising edge where valid && ready;
    // a producer holding valid keeps its data stable until that edge.
    typedef enum logic [1:0] {COLLECT, EVAL, SEND_HDR, SEND_DATA} state_t;

    localparam logic [4:0] LAST_IDX  = 5'(TILE_PIXELS - 1);
    localparam logic [8:0] DELTA_LIM = 9'(1 << DELTA_BITS);

    state_t      state;
    logic [4:0]  pix_cnt;
    logic [4:0]  idx;
    logic [31:0] pix_buf [TILE_PIXELS];
    logic [7:0]  max_c   [4];
    logic [7:0]  min_reg [4];
    logic [7:0]  min_c   [4];
    logic        comp_c;
    logic [47:0] hdr_c;
    logic [4:0]  pay_idx;
    logic [31:0] pay_pixel;
    logic [47:0] pay_data;
    logic [7:0]  delta;

    always_ff @(posedge clk) begin
        if (state == COLLECT && in_valid)
            pix_buf[pix_cnt] <= in_pixel;
    end

    // Min-header block: channel minima over the whole buffer, compressability from running max.
    always_comb begin
        comp_c = 1'b1;
        for (int c = 0; c < 4; c++) begin
            min_c[c] = 8'hFF;
            for (int p = 0; p < TILE_PIXELS; p++)
                if (pix_buf[p][c*8 +: 8] < min_c[c])
                    min_c[c] = pix_buf[p][c*8 +: 8];
            if ({1'b0, max_c[c] - min_c[c]} >= DELTA_LIM)
                comp_c = 1'b0;
        end
        hdr_c = {4'b0, min_c[0], min_c[1], min_c[2], min_c[3], 11'b0, comp_c};
    end

    // Payload for the beat that will be presented after the current handshake.
    always_comb begin
        pay_idx   = (state == SEND_HDR) ? 5'd0 : idx + 5'd1;
        pay_pixel = pix_buf[pay_idx];
        pay_data  = '0;
        delta     = '0;
        if (out_compressed) begin
            for (int c = 0; c < 4; c++) begin
                delta = pay_pixel[c*8 +: 8] - min_reg[c];
                pay_data[c*DELTA_BITS +: DELTA_BITS] = delta[DELTA_BITS-1:0];
            end
        end else begin
            pay_data[31:0] = pay_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= COLLECT;
            pix_cnt        <= '0;
            idx            <= '0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            out_is_hdr     <= 1'b0;
            out_last       <= 1'b0;
            out_compressed <= 1'b0;
            out_data       <= '0;
            for (int c = 0; c < 4; c++) begin
                max_c[c]   <= '0;
                min_reg[c] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        for (int c = 0; c < 4; c++)
                            if (in_pixel[c*8 +: 8] > max_c[c])
                                max_c[c] <= in_pixel[c*8 +: 8];
                        pix_cnt <= pix_cnt + 5'd1;
                        if (pix_cnt == LAST_IDX) begin
                            state    <= EVAL;
                            in_ready <= 1'b0;
                        end
                    end
                end
                EVAL: begin
                    for (int c = 0; c < 4; c++)
                        min_reg[c] <= min_c[c];
                    out_data       <= hdr_c;
                    out_compressed <= comp_c;
                    out_valid      <= 1'b1;
                    out_is_hdr     <= 1'b1;
                    state          <= SEND_HDR;
                end
                SEND_HDR: begin
                    if (out_ready) begin
                        idx        <= '0;
                        out_is_hdr <= 1'b0;
                        out_data   <= pay_data;
                        out_last   <= (TILE_PIXELS == 1);
                        state      <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            in_ready  <= 1'b1;
                            state     <= COLLECT;
                            for (int c = 0; c < 4; c++)
                                max_c[c] <= '0;
                        end else begin
                            idx      <= idx + 5'd1;
                            out_data <= pay_data;
                            out_last <= (idx + 5'd1 == LAST_IDX);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef TILE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tiles_comp <= '0;
            stat_tiles_raw  <= '0;
        end else if (state == SEND_DATA && out_ready && idx == LAST_IDX) begin
            if (out_compressed)
                stat_tiles_comp <= stat_tiles_comp + 32'd1;
            else
                stat_tiles_raw  <= stat_tiles_raw + 32'd1;
        end
    end
`else
    assign stat_tiles_comp = '0;
    assign stat_tiles_raw  = '0;
`endif

endmodule
